// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared definitions for the AXI4-Lite data-memory responder and its initiators.
package axi_lite_mem_slave_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    // Range test done on the offset so that base + span may exceed 32 bits.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W:0]   span);
        logic [ADDR_W-1:0] offset;
        offset = addr - base;
        return (addr >= base) && ({1'b0, offset} < span);
    endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between the LSU initiator and the memory responder.
interface axi_lite_mem_slave_if;
    import axi_lite_mem_slave_pkg::*;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_lite_mem_slave_mem_array.sv
// Word-wide storage with one registered read port and one byte-enabled write port.
module mem_array
    import axi_lite_mem_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Registered read; a same-edge write to the same word is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder standing in for LSU data memory; independent read and write FSMs.
//
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR
//   R_WAIT | latency timer running on the captured read address
//   R_RESP | rvalid high, rdata/rresp frozen until rready
//   W_IDLE | collecting AW and W in any order, each latched once accepted
//   W_WAIT | both halves held, latency timer running
//   W_RESP | array already written, bvalid high until bready
module axi_lite_mem_slave
    import axi_lite_mem_slave_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h8000_0000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                RD_LATENCY  = 1,
    parameter int                WR_LATENCY  = 1
) (
    input logic                 clk,
    input logic                 rst,
    axi_lite_mem_slave_if.slave bus
);

    localparam int                IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   SPAN        = (ADDR_W + 1)'(DEPTH_WORDS) << 2;
    localparam int                RD_CNT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
    localparam int                WR_CNT_W    = (WR_LATENCY > 2) ? $clog2(WR_LATENCY - 1) : 1;
    localparam logic [RD_CNT_W-1:0] RD_CNT_LOAD = RD_CNT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [WR_CNT_W-1:0] WR_CNT_LOAD = WR_CNT_W'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);

    rd_state_t         r_state, r_next;
    logic [RD_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0] ar_addr_q, rd_addr;
    logic              rd_go, rd_in_range, rd_ok_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] mem_rdata;

    wr_state_t         w_state, w_next;
    logic [WR_CNT_W-1:0] w_cnt;
    logic              aw_held, w_held, aw_hs, w_hs, wr_go, wr_in_range;
    logic              awready, wready;
    logic [ADDR_W-1:0] aw_addr_q, wr_addr;
    logic [DATA_W-1:0] wdata_q, wr_data;
    logic [STRB_W-1:0] wstrb_q, wr_strb;
    logic [1:0]        bresp_q;

    // With a 1-cycle latency the read address comes straight off the bus.
    assign rd_addr     = (r_state == R_IDLE) ? bus.araddr : ar_addr_q;
    assign rd_in_range = addr_in_range(rd_addr, ADDR_BASE, SPAN);

    // Read state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read next-state; rd_go marks the edge that enters R_RESP and samples the array.
    always_comb begin
        r_next = r_state;
        rd_go  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (bus.arvalid) begin
                    if (RD_LATENCY == 1) begin
                        r_next = R_RESP;
                        rd_go  = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == '0) begin
                    r_next = R_RESP;
                    rd_go  = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read address capture, latency down-counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_addr_q <= '0;
            r_cnt     <= '0;
            rd_ok_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (r_state == R_IDLE && bus.arvalid) begin
                ar_addr_q <= bus.araddr;
                r_cnt     <= RD_CNT_LOAD;
            end else if (r_state == R_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (rd_go) begin
                rd_ok_q <= rd_in_range;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rd_ok_q ? mem_rdata : '0;

    // Readies depend only on state and held flags, never on the valids.
    assign awready     = (w_state == W_IDLE) && !aw_held;
    assign wready      = (w_state == W_IDLE) && !w_held;
    assign aw_hs       = bus.awvalid && awready;
    assign w_hs        = bus.wvalid && wready;
    assign wr_addr     = aw_hs ? bus.awaddr : aw_addr_q;
    assign wr_data     = w_hs ? bus.wdata : wdata_q;
    assign wr_strb     = w_hs ? bus.wstrb : wstrb_q;
    assign wr_in_range = addr_in_range(wr_addr, ADDR_BASE, SPAN);

    // Write state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write next-state; wr_go marks the edge that enters W_RESP and updates the array.
    always_comb begin
        w_next = w_state;
        wr_go  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    if (WR_LATENCY == 1) begin
                        w_next = W_RESP;
                        wr_go  = 1'b1;
                    end else begin
                        w_next = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt == '0) begin
                    w_next = W_RESP;
                    wr_go  = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // AW/W latches with held flags, latency down-counter and write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            w_cnt     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (w_state == W_RESP && bus.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= bus.awaddr;
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= bus.wdata;
                    wstrb_q <= bus.wstrb;
                end
            end
            if (w_state == W_IDLE && w_next == W_WAIT) begin
                w_cnt <= WR_CNT_LOAD;
            end else if (w_state == W_WAIT && w_cnt != '0) begin
                w_cnt <= w_cnt - 1'b1;
            end
            if (wr_go) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

    // Array write is suppressed during reset so a dropped write never lands.
    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rd_en   (rd_go),
        .rd_idx  (IDX_W'((rd_addr - ADDR_BASE) >> 2)),
        .rd_data (mem_rdata),
        .wr_en   (wr_go && wr_in_range && !rst),
        .wr_idx  (IDX_W'((wr_addr - ADDR_BASE) >> 2)),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: directed cases plus random traffic against a word-array model.
module tb_axi_lite_mem_slave;
    import axi_lite_mem_slave_pkg::*;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 1024;
    localparam int          RD_LAT = 4;
    localparam int          WR_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_mem_slave_if bus();

    axi_lite_mem_slave #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .RD_LATENCY  (RD_LAT),
        .WR_LATENCY  (WR_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Drive AW and W; w_lead > 0 puts W that many cycles ahead of AW, < 0 puts AW ahead.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, output logic [1:0] resp, output int lat);
        bit aw_done, w_done, aw_rdy, w_rdy;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11; lat = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            if (w_done && !aw_done) check_val("wready_after_w_hs", 32'(bus.wready), 32'd0);
            bus.awvalid = !aw_done && (cyc >= w_lead);
            bus.wvalid  = !w_done && (cyc >= -w_lead);
            aw_rdy = bus.awready;
            w_rdy  = bus.wready;
            @(posedge clk);
            if (bus.awvalid && aw_rdy) aw_done = 1;
            if (bus.wvalid && w_rdy)   w_done  = 1;
            cyc++;
        end
        #1;
        bus.awvalid = 0;
        bus.wvalid  = 0;
        check_val("aw_w_handshake", 32'({aw_done, w_done}), 32'd3);
        if (!(aw_done && w_done)) return;
        lat = 1;
        while (!bus.bvalid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.bvalid) return;
        resp = bus.bresp;
        @(negedge clk);
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        check_val("bvalid_after_hs", 32'(bus.bvalid), 32'd0);
        check_val("awready_after_hs", 32'({bus.awready, bus.wready}), 32'd3);
    endtask

    // Issue one read; hold rready low for 'hold' cycles once rvalid is up.
    task automatic do_read(input logic [31:0] a, input int start_dly, input int hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit rdy, done;
        int cyc;
        data = '1; resp = 2'b11; lat = 0; done = 0; cyc = 0;
        repeat (start_dly) @(negedge clk);
        bus.araddr = a;
        while (!done && cyc < 50) begin
            @(negedge clk);
            bus.arvalid = 1;
            rdy = bus.arready;
            @(posedge clk);
            done = rdy;
            cyc++;
        end
        #1;
        bus.arvalid = 0;
        check_val("ar_handshake", 32'(done), 32'd1);
        if (!done) return;
        lat = 1;
        while (!bus.rvalid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rvalid) return;
        data = bus.rdata;
        resp = bus.rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("rvalid_hold", 32'(bus.rvalid), 32'd1);
            check_val("rdata_hold", bus.rdata, data);
            check_val("rresp_hold", 32'(bus.rresp), 32'(resp));
            check_val("arready_hold", 32'(bus.arready), 32'd0);
        end
        @(negedge clk);
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        check_val("rvalid_after_hs", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic write_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead);
        logic [1:0] resp;
        int         lat;
        bit         ok;
        int         idx;
        ok  = ref_in_range(a);
        idx = ref_idx(a);
        do_write(a, d, s, w_lead, resp, lat);
        check_val("bresp", 32'(resp), ok ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
        check_val("b_latency", 32'(lat), 32'(WR_LAT));
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic read_expect(input logic [31:0] a, input int hold,
                               input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(a, 0, hold, d, r, lat);
        check_val("rdata", d, exp_d);
        check_val("rresp", 32'(r), 32'(exp_r));
        check_val("r_latency", 32'(lat), 32'(RD_LAT));
    endtask

    task automatic read_chk(input logic [31:0] a, input int hold);
        if (ref_in_range(a)) read_expect(a, hold, model[ref_idx(a)], RESP_OKAY);
        else                  read_expect(a, hold, 32'd0, RESP_SLVERR);
    endtask

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      return BASE - 32'(4 * $urandom_range(1, 4));
        else if (sel == 1) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        else if (sel == 2) return $urandom;
        else               return BASE + 32'($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(0, 3));
    endfunction

    logic [31:0] c_old, c_new, c_rd;
    logic [1:0]  c_wr_resp, c_rd_resp;
    int          c_wlat, c_rlat;
    logic [31:0] sum_dut, sum_ref, rd_d;
    logic [1:0]  rd_r;
    int          rd_l;
    bit          seen_resp;
    int          tgt;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0; bus.bready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_arready", 32'(bus.arready), 32'd1);
        check_val("rst_awready", 32'(bus.awready), 32'd1);
        check_val("rst_wready", 32'(bus.wready), 32'd1);
        check_val("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_val("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check_val("rst_rdata", bus.rdata, 32'd0);
        check_val("rst_rresp", 32'(bus.rresp), 32'd0);
        check_val("rst_bresp", 32'(bus.bresp), 32'd0);
        rst = 0;

        for (int i = 0; i < DEPTH; i++) write_chk(BASE + 32'(4 * i), $urandom, 4'hF, 0);

        write_chk(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        read_expect(32'h8000_0010, 0, 32'hDEAD_BEEF, RESP_OKAY);
        write_chk(32'h8000_0010, 32'h0000_AB00, 4'b0010, 0);
        read_expect(32'h8000_0010, 0, 32'hDEAD_ABEF, RESP_OKAY);
        write_chk(32'h8000_0020, 32'h1234_5678, 4'hF, 3);
        read_expect(32'h8000_0020, 0, 32'h1234_5678, RESP_OKAY);
        write_chk(32'h8000_0024, 32'hCAFE_F00D, 4'hF, -2);
        read_expect(32'h8000_0024, 0, 32'hCAFE_F00D, RESP_OKAY);
        read_expect(32'h8000_0020, 5, 32'h1234_5678, RESP_OKAY);

        read_expect(32'h7FFF_FFFC, 0, 32'd0, RESP_SLVERR);
        write_chk(32'h8000_1000, 32'hA5A5_5A5A, 4'hF, 0);
        write_chk(32'h7FFF_FFFC, 32'h5A5A_A5A5, 4'hF, 1);
        read_expect(32'h8000_1000, 0, 32'd0, RESP_SLVERR);

        c_old = model[16];
        c_new = c_old ^ 32'hFFFF_0000;
        fork
            do_write(32'h8000_0040, c_new, 4'hF, 0, c_wr_resp, c_wlat);
            do_read(32'h8000_0040, 0, 0, c_rd, c_rd_resp, c_rlat);
        join
        model[16] = c_new;
        check_val("collide_same_edge_old", c_rd, c_old);
        check_val("collide_bresp", 32'(c_wr_resp), 32'(RESP_OKAY));
        c_new = c_new + 32'h0101_0101;
        fork
            do_write(32'h8000_0040, c_new, 4'hF, 0, c_wr_resp, c_wlat);
            do_read(32'h8000_0040, 1, 0, c_rd, c_rd_resp, c_rlat);
        join
        model[16] = c_new;
        check_val("collide_later_edge_new", c_rd, c_new);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0)
                write_chk(pick_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3);
            else
                read_chk(pick_addr(), int'($urandom_range(0, 3)));
        end

        sum_dut = '0;
        sum_ref = '0;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(BASE + 32'(4 * i), 0, 0, rd_d, rd_r, rd_l);
            sum_dut = sum_dut + rd_d;
            sum_ref = sum_ref + model[i];
        end
        check_val("array_checksum", sum_dut, sum_ref);

        tgt = 32;
        @(negedge clk);
        check_val("ready_before_abort", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);
        bus.araddr = BASE + 32'h84; bus.arvalid = 1;
        bus.awaddr = BASE + 32'(4 * tgt); bus.wdata = ~model[tgt]; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_val("abort_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);
        seen_resp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_resp = seen_resp | bus.rvalid | bus.bvalid;
        end
        check_val("abort_no_response", 32'(seen_resp), 32'd0);
        read_expect(BASE + 32'(4 * tgt), 0, model[tgt], RESP_OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite responder that terminates the data-memory port of the LSU and serves word-wide reads and byte-masked writes from an internal memory array. Read and write paths are independent FSMs with parameterised response latency. The block stands in for data memory in simulation and is the target the LSU's AR/R/AW/W/B initiator logic talks to.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `RD_LATENCY`, default 1: cycles from the AR handshake edge to `rvalid` high; must be ≥1.
- `WR_LATENCY`, default 1: cycles from the edge completing both AW and W to `bvalid` high; must be ≥1.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: reset; synchronous, active-high.
- `araddr` in 32: read byte address.
- `arvalid` in 1, `arready` out 1: AR handshake.
- `rdata` out 32, `rresp` out 2: read data and response.
- `rvalid` out 1, `rready` in 1: R handshake.
- `awaddr` in 32: write byte address.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `wdata` in 32: write data.
- `wstrb` in 4: byte lane enables.
- `wvalid` in 1, `wready` out 1: W handshake.
- `bresp` out 2: write response.
- `bvalid` out 1, `bready` in 1: B handshake.

## Operation
- **Address decode**
  - Word index = (addr − `ADDR_BASE`) >> 2. `addr[1:0]` is ignored.
  - In range iff `ADDR_BASE` ≤ addr < `ADDR_BASE` + 4·`DEPTH_WORDS`.
  - Out of range: response is SLVERR (2'b10), `rdata` is 0, and no array write occurs.
  - In range: response is OKAY (2'b00).
- **Read FSM**
  - R_IDLE: `arready`=1. On `arvalid`, capture `araddr` and go to R_WAIT, or go straight to R_RESP when `RD_LATENCY`=1.
  - R_WAIT: `arready`=0. The counter is loaded with `RD_LATENCY`−2 on entry. At count 0, go to R_RESP.
  - On the edge entering R_RESP, the array word is registered into `rdata` and `rresp` is set.
  - R_RESP: `rvalid`=1. `rdata` and `rresp` stay stable until `rvalid & rready`, then go to R_IDLE.
- **Write FSM**
  - W_IDLE: `awready` = !aw_held and `wready` = !w_held. AW and W are accepted in either order or in the same cycle, and each is latched.
  - Once both are held, go to W_WAIT, or straight to W_RESP when `WR_LATENCY`=1.
  - On the edge entering W_RESP, the array is written. Only bytes with a set `wstrb` bit change. `bresp` is set.
  - W_RESP: `bvalid`=1, held until `bvalid & bready`. Then the held flags clear and the FSM returns to W_IDLE.
  - `awready` and `wready` are 0 in W_WAIT and W_RESP.
- **One transaction in flight per direction**; there is no pipelining of ARs or writes.

## Timing
- **Reset values**
  - `arready` = `awready` = `wready` = 1.
  - `rvalid` = `bvalid` = 0.
  - `rdata` = 0, `rresp` = `bresp` = 2'b00.
  - All FSMs idle, held flags cleared. The memory array is not reset.
- **Latency**
  - AR accepted at edge k gives `rvalid` high from edge k+`RD_LATENCY`.
  - The second of AW/W accepted at edge k gives `bvalid` high from edge k+`WR_LATENCY`.
- **Ready behaviour**
  - `*ready` outputs are pure functions of state and held flags; they never combinationally depend on `*valid`.
- **Read/write collision**
  - If the read capture edge and the write edge coincide on the same word, the read returns the old data.
  - A read captured on any later edge sees the new data.
- **Backpressure**
  - With `rready`/`bready` held low indefinitely, the response and its payload remain stable and no new request is accepted on that channel.
  - The other channel is unaffected.
- **Reset mid-operation**
  - Any outstanding transaction is dropped with no response.
  - A write whose array-update edge has not yet occurred does not modify memory.

## Structure
- **Shared package**
  - Response codes `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10, shared with the LSU and IFU initiators.
  - Read and write state enums.
- **Sub-module `mem_array`**
  - Parameters: `DEPTH_WORDS`, 32-bit width.
  - One registered read port and one write port with a 4-bit byte enable.
  - Instantiated once; address decode stays in the top level.

## Test plan
- Write 0x8000_0010 ← 0xDEADBEEF with `wstrb`=4'hF, AW and W in the same cycle, then read 0x8000_0010 → `bresp`=OKAY and `rdata`=0xDEADBEEF, with `bvalid`/`rvalid` exactly `WR_LATENCY`/`RD_LATENCY` cycles after the handshakes.
- After the previous test, write 0x0000AB00 with `wstrb`=4'b0010 → a readback gives 0xDEADABEF.
- Assert W three cycles before AW (address 0x8000_0020, data 0x1234_5678) → `wready` drops after the W handshake, `bvalid` rises `WR_LATENCY` cycles after the AW handshake, and readback is 0x1234_5678.
- Read with `rready` held low for 5 cycles → `rvalid`, `rdata` and `rresp` are stable throughout, and `arready`=0 until the R handshake.
- Read 0x7FFF_FFFC and write 0x8000_1000 with `DEPTH_WORDS`=1024 → both responses are SLVERR, `rdata`=0, and a full-array checksum is unchanged.
- Pulse `rst` in R_WAIT and in W_WAIT with `RD_LATENCY`=`WR_LATENCY`=4 → no `rvalid`/`bvalid`, all readies are 1 on the next cycle, and the target word is unchanged.
